// File: rtl/dse_perfcnt_harden.sv
// DSE performance-counter producer: saturating cumulative event counters with a
// windowed snapshot offered over valid/ready; dse_reset_valid flushes a run.
module dse_perfcnt_harden #(
  parameter int NUM_EVENTS  = 8,
  parameter int EVENT_WIDTH = 6,
  parameter int CNT_WIDTH   = 64,
  parameter int WINDOW      = 1024
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_EVENTS*EVENT_WIDTH-1:0] event_inc,
  input  logic                            dse_reset_valid,
  output logic                            snap_valid,
  input  logic                            snap_ready,
  output logic [NUM_EVENTS*CNT_WIDTH-1:0] snap_data,
  output logic [15:0]                     snap_seq,
  output logic [63:0]                     snap_cycles,
  output logic [15:0]                     snap_dropped
);

  localparam int WIN_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [EVENT_WIDTH-1:0] b);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, a} + (CNT_WIDTH+1)'(b);
    return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] a);
    return (a == 16'hFFFF) ? a : a + 16'd1;
  endfunction

  logic [NUM_EVENTS*CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_nx;
  logic [WIN_W-1:0]                win_q, win_d;
  logic [63:0]                     cyc_q, cyc_d;
  logic [15:0]                     seq_q, seq_d;
  logic                            snap_valid_q, snap_valid_d;
  logic [NUM_EVENTS*CNT_WIDTH-1:0] snap_data_q, snap_data_d;
  logic [15:0]                     snap_seq_q, snap_seq_d;
  logic [63:0]                     snap_cycles_q, snap_cycles_d;
  logic [15:0]                     snap_dropped_q, snap_dropped_d;
  logic                            close, slot_free, accept;

  always_comb begin
    cnt_nx = '0;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      cnt_nx[i*CNT_WIDTH +: CNT_WIDTH] = sat_add(cnt_q[i*CNT_WIDTH +: CNT_WIDTH],
                                                 event_inc[i*EVENT_WIDTH +: EVENT_WIDTH]);
    end
  end

  always_comb begin
    close          = (win_q == WIN_LAST);
    accept         = snap_valid_q && snap_ready;
    slot_free      = !snap_valid_q || snap_ready;
    cnt_d          = cnt_q;
    win_d          = win_q;
    cyc_d          = cyc_q;
    seq_d          = seq_q;
    snap_valid_d   = snap_valid_q;
    snap_data_d    = snap_data_q;
    snap_seq_d     = snap_seq_q;
    snap_cycles_d  = snap_cycles_q;
    snap_dropped_d = snap_dropped_q;
    // Flush wins over a coincident close; the pending snapshot is discarded.
    if (dse_reset_valid) begin
      cnt_d          = '0;
      win_d          = '0;
      cyc_d          = '0;
      seq_d          = '0;
      snap_dropped_d = '0;
      snap_valid_d   = 1'b0;
    end else begin
      cnt_d = cnt_nx;
      cyc_d = cyc_q + 64'd1;
      win_d = close ? '0 : win_q + 1'b1;
      if (close) begin
        seq_d = seq_q + 16'd1;
        if (slot_free) begin
          snap_data_d   = cnt_nx;
          snap_cycles_d = cyc_q + 64'd1;
          snap_seq_d    = seq_q;
          snap_valid_d  = 1'b1;
        end else begin
          snap_dropped_d = sat_inc16(snap_dropped_q);
        end
      end else if (accept) begin
        snap_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q          <= '0;
      win_q          <= '0;
      cyc_q          <= '0;
      seq_q          <= '0;
      snap_valid_q   <= 1'b0;
      snap_data_q    <= '0;
      snap_seq_q     <= '0;
      snap_cycles_q  <= '0;
      snap_dropped_q <= '0;
    end else begin
      cnt_q          <= cnt_d;
      win_q          <= win_d;
      cyc_q          <= cyc_d;
      seq_q          <= seq_d;
      snap_valid_q   <= snap_valid_d;
      snap_data_q    <= snap_data_d;
      snap_seq_q     <= snap_seq_d;
      snap_cycles_q  <= snap_cycles_d;
      snap_dropped_q <= snap_dropped_d;
    end
  end

  assign snap_valid   = snap_valid_q;
  assign snap_data    = snap_data_q;
  assign snap_seq     = snap_seq_q;
  assign snap_cycles  = snap_cycles_q;
  assign snap_dropped = snap_dropped_q;

endmodule

// File: tb/tb_dse_perfcnt_harden.sv
// Directed bench for dse_perfcnt_harden: expected snapshots are queued at window
// close and compared when the endpoint accepts them.
module tb_dse_perfcnt_harden;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         dse_reset_valid = 1'b0;
  logic         snap_ready = 1'b0;
  logic [11:0]  event_inc = 12'd0;
  logic         snap_valid;
  logic [127:0] snap_data;
  logic [15:0]  snap_seq;
  logic [63:0]  snap_cycles;
  logic [15:0]  snap_dropped;

  logic [5:0]   sat_inc = 6'd63;
  logic         sat_flush = 1'b0;
  logic         sat_ready = 1'b1;
  logic         sat_valid;
  logic [7:0]   sat_data;
  logic [15:0]  sat_seq;
  logic [63:0]  sat_cycles;
  logic [15:0]  sat_dropped;

  dse_perfcnt_harden #(.NUM_EVENTS(2), .EVENT_WIDTH(6), .CNT_WIDTH(64), .WINDOW(16)) dut (
    .clock(clock), .reset(reset), .event_inc(event_inc), .dse_reset_valid(dse_reset_valid),
    .snap_valid(snap_valid), .snap_ready(snap_ready), .snap_data(snap_data),
    .snap_seq(snap_seq), .snap_cycles(snap_cycles), .snap_dropped(snap_dropped));

  dse_perfcnt_harden #(.NUM_EVENTS(1), .EVENT_WIDTH(6), .CNT_WIDTH(8), .WINDOW(16)) dut_sat (
    .clock(clock), .reset(reset), .event_inc(sat_inc), .dse_reset_valid(sat_flush),
    .snap_valid(sat_valid), .snap_ready(sat_ready), .snap_data(sat_data),
    .snap_seq(sat_seq), .snap_cycles(sat_cycles), .snap_dropped(sat_dropped));

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] c0;
    logic [63:0] c1;
    logic [63:0] cycles;
    logic [15:0] seq;
  } snap_t;

  snap_t       sb[$];
  logic [63:0] m_c0, m_c1, m_cyc;
  int          m_win;
  logic [15:0] m_seq, m_drop;
  logic        m_vld;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_c0 = 0; m_c1 = 0; m_cyc = 0; m_win = 0;
    m_seq = 0; m_drop = 0; m_vld = 1'b0;
    sb.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1; dse_reset_valid = 1'b0; snap_ready = 1'b0;
    event_inc = {6'd3, 6'd1};
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  // One clock cycle: ev0=1, ev1=3 each cycle; rdy/fl are the cycle's inputs.
  task automatic step(input logic rdy, input logic fl);
    snap_t e;
    snap_ready = rdy;
    dse_reset_valid = fl;
    event_inc = {6'd3, 6'd1};
    if (!fl && snap_valid && rdy) begin
      chk("sb_nonempty", 128'(sb.size() != 0), 128'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("acc_c0", snap_data[63:0], e.c0);
        chk("acc_c1", snap_data[127:64], e.c1);
        chk("acc_cycles", snap_cycles, e.cycles);
        chk("acc_seq", snap_seq, e.seq);
      end
    end
    if (fl) begin
      model_clear();
    end else begin
      m_c0 += 1;
      m_c1 += 3;
      if (m_win == 15) begin
        if (!m_vld || rdy) begin
          e.c0 = m_c0; e.c1 = m_c1; e.cycles = m_cyc + 1; e.seq = m_seq;
          sb.push_back(e);
          m_vld = 1'b1;
        end else if (m_drop != 16'hFFFF) begin
          m_drop += 1;
        end
        m_seq += 1;
        m_win = 0;
      end else begin
        m_win++;
        if (m_vld && rdy) m_vld = 1'b0;
      end
      m_cyc += 1;
    end
    @(posedge clock);
    #1;
    chk("valid", snap_valid, m_vld);
    chk("dropped", snap_dropped, m_drop);
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_valid", snap_valid, 0);
    chk("rst_data", snap_data, 0);
    chk("rst_seq", snap_seq, 0);
    chk("rst_cycles", snap_cycles, 0);
    chk("rst_dropped", snap_dropped, 0);
    chk("rst_sat_data", sat_data, 0);

    // Basic capture with ready held high, plus saturating instance alongside
    repeat (16) step(1'b1, 1'b0);
    chk("basic1_c0", snap_data[63:0], 16);
    chk("basic1_c1", snap_data[127:64], 48);
    chk("basic1_cycles", snap_cycles, 16);
    chk("basic1_seq", snap_seq, 0);
    chk("sat1_valid", sat_valid, 1);
    chk("sat1_data", sat_data, 255);
    repeat (16) step(1'b1, 1'b0);
    chk("basic2_c0", snap_data[63:0], 32);
    chk("basic2_c1", snap_data[127:64], 96);
    chk("basic2_cycles", snap_cycles, 32);
    chk("basic2_seq", snap_seq, 1);
    chk("sat2_data", sat_data, 255);
    chk("sat2_dropped", sat_dropped, 0);

    // Backpressure drop
    do_reset();
    repeat (40) step(1'b0, 1'b0);
    chk("bp_dropped", snap_dropped, 1);
    chk("bp_hold_seq", snap_seq, 0);
    chk("bp_hold_c0", snap_data[63:0], 16);
    chk("bp_hold_cycles", snap_cycles, 16);
    step(1'b1, 1'b0);
    repeat (7) step(1'b0, 1'b0);
    chk("bp_next_valid", snap_valid, 1);
    chk("bp_next_seq", snap_seq, 2);
    chk("bp_next_cycles", snap_cycles, 48);
    chk("bp_next_c0", snap_data[63:0], 48);
    step(1'b1, 1'b0);

    // Coincident accept and capture
    do_reset();
    repeat (31) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("coin_valid", snap_valid, 1);
    chk("coin_seq", snap_seq, 1);
    chk("coin_dropped", snap_dropped, 0);
    chk("coin_cycles", snap_cycles, 32);
    step(1'b1, 1'b0);

    // Flush mid-handshake
    do_reset();
    repeat (20) step(1'b0, 1'b0);
    chk("fmid_pre_valid", snap_valid, 1);
    step(1'b0, 1'b1);
    chk("fmid_valid_drop", snap_valid, 0);
    repeat (16) step(1'b0, 1'b0);
    chk("fmid_valid", snap_valid, 1);
    chk("fmid_seq", snap_seq, 0);
    chk("fmid_cycles", snap_cycles, 16);
    chk("fmid_c0", snap_data[63:0], 16);
    chk("fmid_c1", snap_data[127:64], 48);
    chk("fmid_dropped", snap_dropped, 0);
    step(1'b1, 1'b0);

    // Flush on the close cycle
    do_reset();
    repeat (15) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("fclose_no_snap", snap_valid, 0);
    repeat (15) step(1'b1, 1'b0);
    chk("fclose_still_idle", snap_valid, 0);
    step(1'b1, 1'b0);
    chk("fclose_valid", snap_valid, 1);
    chk("fclose_cycles", snap_cycles, 16);
    chk("fclose_seq", snap_seq, 0);
    step(1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
